// File: rtl/pkt_buffer_mc_pkg.sv
// pkt_buffer_mc shared types: cell metadata bundle,
// free-list sequencer states and port limits.
package pkt_buffer_mc_pkg;

  localparam int PB_MAX_RD = 4;
  localparam int PB_LEN_W  = 7;

  typedef struct packed {
    logic                sof;
    logic                eof;
    logic [PB_LEN_W-1:0] len;
  } pb_cell_meta_t;

  typedef enum logic {
    FL_INIT,
    FL_RUN
  } fl_state_e;

endpackage

// File: rtl/pkt_buffer_mc_if.sv
// pkt_buffer_mc bus: allocation, release, write
// and per-port read request/response signals.
interface pkt_buffer_mc_if #(
  parameter int CID_W  = 10,
  parameter int CELL_W = 512,
  parameter int NUM_RD = 2,
  parameter int REF_W  = 4,
  parameter int LEN_W  = 7
);

  logic                      alloc_req;
  logic [REF_W-1:0]          alloc_refcnt;
  logic                      alloc_valid;
  logic [CID_W-1:0]          alloc_id;
  logic                      free_req;
  logic [CID_W-1:0]          free_id;
  logic                      wr_valid;
  logic [CID_W-1:0]          wr_cell_id;
  logic [CELL_W-1:0]         wr_data;
  logic                      wr_sof;
  logic                      wr_eof;
  logic [LEN_W-1:0]          wr_len;
  logic [NUM_RD-1:0]         rd_req_valid;
  logic [NUM_RD*CID_W-1:0]   rd_req_cell_id;
  logic [NUM_RD-1:0]         rd_rsp_valid;
  logic [NUM_RD*CELL_W-1:0]  rd_rsp_data;
  logic [NUM_RD-1:0]         rd_rsp_sof;
  logic [NUM_RD-1:0]         rd_rsp_eof;
  logic [NUM_RD*LEN_W-1:0]   rd_rsp_len;
  logic [CID_W:0]            free_cnt;
  logic                      err_alloc_empty;
  logic                      err_dbl_free;

  modport master (
    output alloc_req, alloc_refcnt, free_req, free_id,
    output wr_valid, wr_cell_id, wr_data, wr_sof, wr_eof,
    output wr_len, rd_req_valid, rd_req_cell_id,
    input  alloc_valid, alloc_id, free_cnt,
    input  rd_rsp_valid, rd_rsp_data, rd_rsp_sof,
    input  rd_rsp_eof, rd_rsp_len,
    input  err_alloc_empty, err_dbl_free
  );

  modport slave (
    input  alloc_req, alloc_refcnt, free_req, free_id,
    input  wr_valid, wr_cell_id, wr_data, wr_sof, wr_eof,
    input  wr_len, rd_req_valid, rd_req_cell_id,
    output alloc_valid, alloc_id, free_cnt,
    output rd_rsp_valid, rd_rsp_data, rd_rsp_sof,
    output rd_rsp_eof, rd_rsp_len,
    output err_alloc_empty, err_dbl_free
  );

endinterface

// File: rtl/pkt_buffer_mc_free_list.sv
// Cell-ID FIFO with self-initialising fill sequence,
// occupancy counter and registered show-ahead head.
module pkt_buffer_mc_free_list
  import pkt_buffer_mc_pkg::*;
#(
  parameter int NUM_CELLS = 1024,
  parameter int CID_W     = $clog2(NUM_CELLS)
) (
  input  logic             clk_dp,
  input  logic             rst_dp,
  input  logic             pop,
  input  logic             push,
  input  logic [CID_W-1:0] push_id,
  output logic             run,
  output logic             alloc_valid,
  output logic [CID_W-1:0] alloc_id,
  output logic [CID_W:0]   free_cnt
);

  fl_state_e        state;
  logic [CID_W-1:0] fifo [NUM_CELLS];
  logic [CID_W-1:0] wr_ptr;
  logic [CID_W-1:0] rd_ptr;
  logic [CID_W-1:0] init_id;
  logic [CID_W-1:0] nxt_rd;
  logic [CID_W-1:0] in_id;
  logic             do_push;
  logic             do_pop;

  assign run         = (state == FL_RUN);
  assign alloc_valid = run && (free_cnt != '0);

  always_comb begin
    do_push = run ? push : 1'b1;
    in_id   = run ? push_id : init_id;
    do_pop  = pop && alloc_valid;
    nxt_rd  = rd_ptr + CID_W'(do_pop);
  end

  always_ff @(posedge clk_dp) begin
    if (do_push)
      fifo[wr_ptr] <= in_id;
  end

  // head bypass: a push into an emptying list becomes the new head
  always_ff @(posedge clk_dp or posedge rst_dp) begin
    if (rst_dp) begin
      state    <= FL_INIT;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      init_id  <= '0;
      free_cnt <= '0;
      alloc_id <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      rd_ptr   <= nxt_rd;
      free_cnt <= free_cnt
                + (CID_W+1)'(do_push)
                - (CID_W+1)'(do_pop);
      if (do_push && (wr_ptr == nxt_rd))
        alloc_id <= in_id;
      else
        alloc_id <= fifo[nxt_rd];
      if (!run) begin
        init_id <= init_id + 1'b1;
        if (&init_id)
          state <= FL_RUN;
      end
    end
  end

endmodule

// File: rtl/pkt_buffer_mc.sv
// Shared cell store with per-cell reference counts,
// NUM_RD read ports and a FIFO free list.
module pkt_buffer_mc
  import pkt_buffer_mc_pkg::*;
#(
  parameter int NUM_CELLS = 1024,
  parameter int CELL_W    = 512,
  parameter int NUM_RD    = 2,
  parameter int REF_W     = 4,
  parameter int LEN_W     = 7
) (
  input logic              clk_dp,
  input logic              rst_dp,
  pkt_buffer_mc_if.slave   bus
);

  localparam int CID_W = $clog2(NUM_CELLS);

  typedef struct packed {
    logic             sof;
    logic             eof;
    logic [LEN_W-1:0] len;
  } cell_meta_t;

  logic [CELL_W-1:0] data_mem [NUM_CELLS];
  cell_meta_t        meta_mem [NUM_CELLS];
  logic [REF_W-1:0]  refcnt   [NUM_CELLS];

  logic [CID_W-1:0]  rd_id [NUM_RD];
  logic              run;
  logic              pop;
  logic              free_ok;
  logic              push;
  logic [REF_W-1:0]  free_rc;
  logic [REF_W-1:0]  init_rc;

  logic [NUM_RD-1:0]        rsp_valid;
  logic [NUM_RD*CELL_W-1:0] rsp_data;
  logic [NUM_RD-1:0]        rsp_sof;
  logic [NUM_RD-1:0]        rsp_eof;
  logic [NUM_RD*LEN_W-1:0]  rsp_len;
  logic                     err_empty;
  logic                     err_dbl;

  always_comb begin
    pop     = bus.alloc_req && bus.alloc_valid;
    free_ok = bus.free_req && run;
    free_rc = refcnt[bus.free_id];
    push    = free_ok && (free_rc == REF_W'(1));
    init_rc = (bus.alloc_refcnt == '0) ? REF_W'(1)
                                       : bus.alloc_refcnt;
    for (int p = 0; p < NUM_RD; p++)
      rd_id[p] = bus.rd_req_cell_id[p*CID_W +: CID_W];
  end

  pkt_buffer_mc_free_list #(
    .NUM_CELLS (NUM_CELLS),
    .CID_W     (CID_W)
  ) u_free_list (
    .clk_dp      (clk_dp),
    .rst_dp      (rst_dp),
    .pop         (bus.alloc_req),
    .push        (push),
    .push_id     (bus.free_id),
    .run         (run),
    .alloc_valid (bus.alloc_valid),
    .alloc_id    (bus.alloc_id),
    .free_cnt    (bus.free_cnt)
  );

  // pop assignment comes last so it wins on a same-cell collision
  always_ff @(posedge clk_dp or posedge rst_dp) begin
    if (rst_dp) begin
      for (int i = 0; i < NUM_CELLS; i++)
        refcnt[i] <= '0;
      err_empty <= 1'b0;
      err_dbl   <= 1'b0;
    end else begin
      err_empty <= bus.alloc_req && !bus.alloc_valid && run;
      err_dbl   <= free_ok && (free_rc == '0);
      if (free_ok && (free_rc != '0))
        refcnt[bus.free_id] <= free_rc - 1'b1;
      if (pop)
        refcnt[bus.alloc_id] <= init_rc;
    end
  end

  always_ff @(posedge clk_dp) begin
    if (bus.wr_valid) begin
      data_mem[bus.wr_cell_id] <= bus.wr_data;
      meta_mem[bus.wr_cell_id] <= '{
        sof: bus.wr_sof,
        eof: bus.wr_eof,
        len: bus.wr_len
      };
    end
  end

  always_ff @(posedge clk_dp or posedge rst_dp) begin
    if (rst_dp) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_sof   <= '0;
      rsp_eof   <= '0;
      rsp_len   <= '0;
    end else begin
      rsp_valid <= bus.rd_req_valid;
      for (int p = 0; p < NUM_RD; p++) begin
        if (bus.rd_req_valid[p]) begin
          rsp_data[p*CELL_W +: CELL_W] <= data_mem[rd_id[p]];
          rsp_sof[p] <= meta_mem[rd_id[p]].sof;
          rsp_eof[p] <= meta_mem[rd_id[p]].eof;
          rsp_len[p*LEN_W +: LEN_W] <= meta_mem[rd_id[p]].len;
        end
      end
    end
  end

  assign bus.rd_rsp_valid    = rsp_valid;
  assign bus.rd_rsp_data     = rsp_data;
  assign bus.rd_rsp_sof      = rsp_sof;
  assign bus.rd_rsp_eof      = rsp_eof;
  assign bus.rd_rsp_len      = rsp_len;
  assign bus.err_alloc_empty = err_empty;
  assign bus.err_dbl_free    = err_dbl;

endmodule

// File: tb/tb_pkt_buffer_mc.sv
// pkt_buffer_mc bench: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_pkt_buffer_mc;

  localparam int N  = 16;
  localparam int W  = 64;
  localparam int R  = 2;
  localparam int RW = 4;
  localparam int LW = 7;
  localparam int CW = 4;

  logic clk_dp = 1'b0;
  logic rst_dp = 1'b1;

  always #5 clk_dp = ~clk_dp;

  pkt_buffer_mc_if #(
    .CID_W(CW), .CELL_W(W), .NUM_RD(R),
    .REF_W(RW), .LEN_W(LW)
  ) bus ();

  pkt_buffer_mc #(
    .NUM_CELLS(N), .CELL_W(W), .NUM_RD(R),
    .REF_W(RW), .LEN_W(LW)
  ) dut (
    .clk_dp (clk_dp),
    .rst_dp (rst_dp),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  int          fq[$];
  int          rc[N];
  bit          running;
  int          init_cnt;
  logic [W-1:0]    mdata[N];
  logic [LW+1:0]   mmeta[N];
  bit          mwr[N];
  bit          ev[R];
  bit          ek[R];
  logic [W-1:0]    ed[R];
  logic [LW+1:0]   em[R];
  bit          e_ea;
  bit          e_ed;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_av();
    return running && (fq.size() != 0);
  endfunction

  task automatic model_reset();
    fq.delete();
    for (int i = 0; i < N; i++) rc[i] = 0;
    running  = 0;
    init_cnt = 0;
    for (int p = 0; p < R; p++) begin
      ev[p] = 0; ek[p] = 1; ed[p] = '0; em[p] = '0;
    end
    e_ea = 0;
    e_ed = 0;
  endtask

  task automatic model_step();
    bit av;
    int id;
    int fid;
    av  = m_av();
    fid = int'(bus.free_id);
    e_ea = bus.alloc_req && !av && running;
    e_ed = 0;
    for (int p = 0; p < R; p++) begin
      ev[p] = bus.rd_req_valid[p];
      if (ev[p]) begin
        id = int'(bus.rd_req_cell_id[p*CW +: CW]);
        ek[p] = mwr[id];
        ed[p] = mdata[id];
        em[p] = mmeta[id];
      end
    end
    if (bus.wr_valid) begin
      id = int'(bus.wr_cell_id);
      mdata[id] = bus.wr_data;
      mmeta[id] = {bus.wr_sof, bus.wr_eof, bus.wr_len};
      mwr[id]   = 1;
    end
    if (running && bus.free_req) begin
      if (rc[fid] == 0) e_ed = 1;
      else begin
        rc[fid]--;
        if (rc[fid] == 0) fq.push_back(fid);
      end
    end
    if (bus.alloc_req && av) begin
      id = fq.pop_front();
      rc[id] = (bus.alloc_refcnt == 0) ? 1
             : int'(bus.alloc_refcnt);
    end
    if (!running) begin
      fq.push_back(init_cnt);
      init_cnt++;
      if (init_cnt == N) running = 1;
    end
  endtask

  task automatic check_all();
    chk("free_cnt", 64'(bus.free_cnt), 64'(fq.size()));
    chk("alloc_valid", 64'(bus.alloc_valid), 64'(m_av()));
    if (m_av())
      chk("alloc_id", 64'(bus.alloc_id), 64'(fq[0]));
    chk("err_alloc_empty", 64'(bus.err_alloc_empty), 64'(e_ea));
    chk("err_dbl_free", 64'(bus.err_dbl_free), 64'(e_ed));
    for (int p = 0; p < R; p++) begin
      chk("rsp_valid", 64'(bus.rd_rsp_valid[p]), 64'(ev[p]));
      if (ek[p]) begin
        chk("rsp_data", bus.rd_rsp_data[p*W +: W], ed[p]);
        chk("rsp_meta",
            64'({bus.rd_rsp_sof[p], bus.rd_rsp_eof[p],
                 bus.rd_rsp_len[p*LW +: LW]}),
            64'(em[p]));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_dp);
    model_step();
    @(negedge clk_dp);
    check_all();
  endtask

  task automatic idle();
    bus.alloc_req      = 0;
    bus.alloc_refcnt   = 4'd1;
    bus.free_req       = 0;
    bus.free_id        = '0;
    bus.wr_valid       = 0;
    bus.wr_cell_id     = '0;
    bus.wr_data        = '0;
    bus.wr_sof         = 0;
    bus.wr_eof         = 0;
    bus.wr_len         = '0;
    bus.rd_req_valid   = '0;
    bus.rd_req_cell_id = '0;
  endtask

  task automatic free_one(input int id);
    bus.free_req = 1;
    bus.free_id  = CW'(id);
    tick();
    bus.free_req = 0;
  endtask

  initial begin
    int x;
    int live[$];
    int order[9] = '{1, 2, 4, 6, 8, 9, 10, 11, 12};
    idle();
    model_reset();
    for (int i = 0; i < N; i++) mwr[i] = 0;
    #1;
    chk("rst_free_cnt", 64'(bus.free_cnt), 64'd0);
    chk("rst_alloc_valid", 64'(bus.alloc_valid), 64'd0);
    chk("rst_alloc_id", 64'(bus.alloc_id), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rd_rsp_valid), 64'd0);
    @(negedge clk_dp);
    rst_dp = 0;

    for (int i = 0; i < N; i++) begin
      tick();
      chk("init_cnt", 64'(bus.free_cnt), 64'(i + 1));
    end
    chk("init_done_valid", 64'(bus.alloc_valid), 64'd1);
    bus.alloc_req = 1;
    for (int i = 0; i < 3; i++) begin
      chk("pop_order", 64'(bus.alloc_id), 64'(i));
      tick();
    end
    bus.alloc_req = 0;
    chk("cnt_after_pops", 64'(bus.free_cnt), 64'd13);

    bus.wr_valid   = 1;
    bus.wr_cell_id = '0;
    bus.wr_data    = 64'hDEAD_BEEF_CAFE_1234;
    bus.wr_sof     = 1;
    bus.wr_eof     = 0;
    bus.wr_len     = 7'd64;
    tick();
    bus.wr_valid       = 0;
    bus.rd_req_valid   = 2'b11;
    bus.rd_req_cell_id = '0;
    tick();
    for (int p = 0; p < R; p++) begin
      chk("mc_valid", 64'(bus.rd_rsp_valid[p]), 64'd1);
      chk("mc_data", bus.rd_rsp_data[p*W +: W],
          64'hDEAD_BEEF_CAFE_1234);
      chk("mc_meta",
          64'({bus.rd_rsp_sof[p], bus.rd_rsp_eof[p],
               bus.rd_rsp_len[p*LW +: LW]}),
          64'({1'b1, 1'b0, 7'd64}));
    end
    bus.rd_req_valid = '0;
    tick();
    chk("hold_valid", 64'(bus.rd_rsp_valid), 64'd0);
    chk("hold_data", bus.rd_rsp_data[W-1:0],
        64'hDEAD_BEEF_CAFE_1234);

    chk("rc3_id", 64'(bus.alloc_id), 64'd3);
    x = fq[0];
    bus.alloc_req    = 1;
    bus.alloc_refcnt = 4'd3;
    tick();
    bus.alloc_req    = 0;
    bus.alloc_refcnt = 4'd1;
    free_one(x);
    chk("rc3_free1", 64'(bus.free_cnt), 64'd12);
    free_one(x);
    chk("rc3_free2", 64'(bus.free_cnt), 64'd12);
    free_one(x);
    chk("rc3_free3", 64'(bus.free_cnt), 64'd13);
    free_one(x);
    chk("dbl_free_pulse", 64'(bus.err_dbl_free), 64'd1);
    tick();
    chk("dbl_free_clear", 64'(bus.err_dbl_free), 64'd0);

    bus.alloc_req = 1;
    for (int i = 0; i < 13; i++) tick();
    chk("empty_valid", 64'(bus.alloc_valid), 64'd0);
    tick();
    chk("empty_pulse", 64'(bus.err_alloc_empty), 64'd1);
    bus.alloc_req = 0;
    free_one(5);
    chk("refill_valid", 64'(bus.alloc_valid), 64'd1);
    chk("refill_id", 64'(bus.alloc_id), 64'd5);

    free_one(7);
    free_one(3);
    bus.alloc_req = 1;
    bus.free_req  = 1;
    bus.free_id   = 4'd0;
    tick();
    bus.free_req  = 0;
    chk("popfree_cnt", 64'(bus.free_cnt), 64'd3);
    chk("fifo_first", 64'(bus.alloc_id), 64'd7);
    tick();
    chk("fifo_second", 64'(bus.alloc_id), 64'd3);
    tick();
    bus.alloc_req = 0;

    foreach (order[i]) free_one(order[i]);
    chk("pre_rst_cnt", 64'(bus.free_cnt), 64'd10);
    bus.rd_req_valid   = 2'b11;
    bus.rd_req_cell_id = 8'h10;
    @(posedge clk_dp);
    #2 rst_dp = 1;
    #1;
    chk("mid_rst_valid", 64'(bus.rd_rsp_valid), 64'd0);
    chk("mid_rst_cnt", 64'(bus.free_cnt), 64'd0);
    model_reset();
    idle();
    @(negedge clk_dp);
    rst_dp = 0;
    for (int i = 0; i < N; i++) tick();
    chk("reinit_id", 64'(bus.alloc_id), 64'd0);
    chk("reinit_cnt", 64'(bus.free_cnt), 64'(N));

    for (int c = 0; c < 3000; c++) begin
      bus.alloc_req    = $urandom_range(0, 1) == 1;
      bus.alloc_refcnt = RW'($urandom_range(0, 3));
      bus.free_req     = 0;
      x = $urandom_range(0, 99);
      if (x < 45) begin
        live.delete();
        for (int i = 0; i < N; i++)
          if (rc[i] > 0) live.push_back(i);
        if (live.size() != 0) begin
          bus.free_req = 1;
          bus.free_id  =
            CW'(live[$urandom_range(0, live.size() - 1)]);
        end
      end else if (x < 55) begin
        bus.free_req = 1;
        bus.free_id  = CW'($urandom_range(0, N - 1));
      end
      bus.wr_valid   = $urandom_range(0, 1) == 1;
      bus.wr_cell_id = CW'($urandom_range(0, N - 1));
      bus.wr_data    = {$urandom(), $urandom()};
      bus.wr_sof     = $urandom_range(0, 1) == 1;
      bus.wr_eof     = $urandom_range(0, 1) == 1;
      bus.wr_len     = LW'($urandom_range(0, 127));
      for (int p = 0; p < R; p++) begin
        bus.rd_req_valid[p] = $urandom_range(0, 1) == 1;
        bus.rd_req_cell_id[p*CW +: CW] =
          CW'($urandom_range(0, N - 1));
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
